// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART constants and receiver/transmitter state type
package uart_pkg;

    localparam int CLKS_PER_BIT_9600_12M = 1250;
    localparam int DATA_BITS             = 8;
    localparam int IDX_W                 = $clog2(DATA_BITS);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_IDLE
    } uart_state_t;

endpackage

// File: rtl/uart_rx_if.sv
// rtl/uart_rx_if.sv - received-byte valid/ready channel with error pulses
interface uart_rx_if;
    import uart_pkg::*;

    logic [DATA_BITS-1:0] data;
    logic                 valid;
    logic                 ready;
    logic                 frame_err;
    logic                 overrun;

    modport master (
        output data,
        output valid,
        output frame_err,
        output overrun,
        input  ready
    );

    modport slave (
        input  data,
        input  valid,
        input  frame_err,
        input  overrun,
        output ready
    );

endinterface

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop synchronizer for asynchronous pins, reset to all ones by default
module sync_2ff #(
    parameter int               WIDTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_meta <= RESET_VAL;
            r_sync <= RESET_VAL;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 UART receiver with a one-entry valid/ready output register
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_9600_12M,
    parameter int CNT_W        = $clog2(CLKS_PER_BIT)
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      rx,
    uart_rx_if.master out_if
);

    localparam logic [CNT_W-1:0] HALF_M1  = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_M1  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);

    logic                 w_rx_s;
    uart_state_t          r_state;
    logic [CNT_W-1:0]     r_cnt;
    logic [IDX_W-1:0]     r_idx;
    logic [DATA_BITS-1:0] r_shift;
    logic [DATA_BITS-1:0] r_data;
    logic                 r_valid;
    logic                 r_frame_err;
    logic                 r_overrun;

    sync_2ff #(
        .WIDTH     (1),
        .RESET_VAL (1'b1)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .i_d (rx),
        .o_q (w_rx_s)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_idx       <= '0;
            r_shift     <= '0;
            r_data      <= '0;
            r_valid     <= 1'b0;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
            // A delivery in STOP below overrides this clear when both coincide.
            if (r_valid && out_if.ready) begin
                r_valid <= 1'b0;
            end
            case (r_state)
                IDLE: begin
                    r_cnt <= '0;
                    if (!w_rx_s) begin
                        r_state <= START;
                    end
                end
                START: begin
                    if (r_cnt == HALF_M1) begin
                        r_cnt   <= '0;
                        r_idx   <= '0;
                        r_state <= w_rx_s ? IDLE : DATA;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (r_cnt == FULL_M1) begin
                        r_cnt   <= '0;
                        r_shift <= {w_rx_s, r_shift[DATA_BITS-1:1]};
                        if (r_idx == LAST_IDX) begin
                            r_state <= STOP;
                        end else begin
                            r_idx <= r_idx + 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (r_cnt == FULL_M1) begin
                        r_cnt <= '0;
                        if (w_rx_s) begin
                            r_state <= IDLE;
                            if (!r_valid || out_if.ready) begin
                                r_data  <= r_shift;
                                r_valid <= 1'b1;
                            end else begin
                                r_overrun <= 1'b1;
                            end
                        end else begin
                            r_frame_err <= 1'b1;
                            r_state     <= WAIT_IDLE;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                // Hold off until the line returns high so a break is not seen as 0x00 frames.
                WAIT_IDLE: begin
                    r_cnt <= '0;
                    if (w_rx_s) begin
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_cnt   <= '0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign out_if.data      = r_data;
    assign out_if.valid     = r_valid;
    assign out_if.frame_err = r_frame_err;
    assign out_if.overrun   = r_overrun;

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - self-checking bench for uart_rx
module tb_uart_rx;

    localparam int CPB = 8;

    typedef struct {
        int         kind;     // 0 good frame, 1 bad stop bit, 2 glitch, 3 ready pulse
        logic [7:0] b;
        bit         rdy;
        int         extra;
        bit         e_valid;
        logic [7:0] e_data;
        int         e_fe;
        int         e_ov;
        int         e_nacc;
        logic [7:0] e_acc0;
        logic [7:0] e_acc1;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    logic rx;

    uart_rx_if u_if ();

    uart_rx #(.CLKS_PER_BIT(CPB)) dut (
        .clk    (clk),
        .rst    (rst),
        .rx     (rx),
        .out_if (u_if.master)
    );

    always #5 clk = ~clk;

    int         n_vec = 0;
    int         n_mis = 0;
    int         fe_cnt = 0;
    int         ov_cnt = 0;
    int         both_cnt = 0;
    logic [7:0] got[$];
    bit         m_valid;
    logic [7:0] m_data;

    always @(negedge clk) begin
        if (!rst) begin
            if (u_if.frame_err) fe_cnt++;
            if (u_if.overrun) ov_cnt++;
            if (u_if.frame_err && u_if.overrun) both_cnt++;
            if (u_if.valid && u_if.ready) got.push_back(u_if.data);
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive_bit(input logic v, input int n);
        rx = v;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop);
        drive_bit(1'b0, CPB);
        for (int i = 0; i < 8; i++) drive_bit(b[i], CPB);
        drive_bit(stop, CPB);
    endtask

    function automatic vec_t mk(input int kind, input logic [7:0] b, input bit rdy, input int extra,
                                input bit ev, input logic [7:0] ed, input int efe, input int eov,
                                input int nacc, input logic [7:0] a0, input logic [7:0] a1);
        vec_t v;
        v.kind = kind; v.b = b; v.rdy = rdy; v.extra = extra;
        v.e_valid = ev; v.e_data = ed; v.e_fe = efe; v.e_ov = eov;
        v.e_nacc = nacc; v.e_acc0 = a0; v.e_acc1 = a1;
        return v;
    endfunction

    // Reference: a one-entry mailbox; ready held over a vector drains any held byte first.
    function automatic vec_t model(input vec_t vin);
        vec_t       v;
        logic [7:0] acc[$];
        v = vin;
        v.e_fe = 0;
        v.e_ov = 0;
        if ((v.rdy || v.kind == 3) && m_valid) begin
            acc.push_back(m_data);
            m_valid = 1'b0;
        end
        if (v.kind == 0) begin
            if (m_valid) begin
                v.e_ov = 1;
            end else begin
                m_data = v.b;
                if (v.rdy) acc.push_back(v.b);
                else m_valid = 1'b1;
            end
        end
        if (v.kind == 1) v.e_fe = 1;
        v.e_valid = m_valid;
        v.e_data  = m_data;
        v.e_nacc  = acc.size();
        v.e_acc0  = (acc.size() > 0) ? acc[0] : 8'h00;
        v.e_acc1  = (acc.size() > 1) ? acc[1] : 8'h00;
        return v;
    endfunction

    task automatic run_vec(input vec_t v, input string tag);
        int fe0 = fe_cnt;
        int ov0 = ov_cnt;
        int g0  = got.size();
        int n;
        u_if.ready = (v.kind == 3) ? 1'b1 : v.rdy;
        case (v.kind)
            0: send_frame(v.b, 1'b1);
            1: begin
                send_frame(v.b, 1'b0);
                if (v.extra > 0) drive_bit(1'b0, v.extra);
            end
            2: drive_bit(1'b0, v.extra);
            default: drive_bit(1'b1, 1);
        endcase
        u_if.ready = 1'b0;
        drive_bit(1'b1, 12);
        n = got.size() - g0;
        chk({tag, ".frame_err"}, fe_cnt - fe0, v.e_fe);
        chk({tag, ".overrun"}, ov_cnt - ov0, v.e_ov);
        chk({tag, ".accepted"}, n, v.e_nacc);
        if (n > 0 && v.e_nacc > 0) chk({tag, ".acc0"}, got[g0], v.e_acc0);
        if (n > 1 && v.e_nacc > 1) chk({tag, ".acc1"}, got[g0+1], v.e_acc1);
        chk({tag, ".valid"}, u_if.valid, v.e_valid);
        chk({tag, ".data"}, u_if.data, v.e_data);
    endtask

    vec_t dir[10];

    initial begin
        vec_t v;
        int   fe0, ov0, g0;

        dir[0] = mk(0, 8'h3F, 1, 0,  0, 8'h3F, 0, 0, 1, 8'h3F, 8'h00);
        dir[1] = mk(0, 8'hAB, 0, 0,  1, 8'hAB, 0, 0, 0, 8'h00, 8'h00);
        dir[2] = mk(3, 8'h00, 0, 0,  0, 8'hAB, 0, 0, 1, 8'hAB, 8'h00);
        dir[3] = mk(2, 8'h00, 0, 3,  0, 8'hAB, 0, 0, 0, 8'h00, 8'h00);
        dir[4] = mk(0, 8'h55, 1, 0,  0, 8'h55, 0, 0, 1, 8'h55, 8'h00);
        dir[5] = mk(1, 8'hA5, 0, 40, 0, 8'h55, 1, 0, 0, 8'h00, 8'h00);
        dir[6] = mk(0, 8'h12, 1, 0,  0, 8'h12, 0, 0, 1, 8'h12, 8'h00);
        dir[7] = mk(0, 8'h01, 0, 0,  1, 8'h01, 0, 0, 0, 8'h00, 8'h00);
        dir[8] = mk(0, 8'h02, 0, 0,  1, 8'h01, 0, 1, 0, 8'h00, 8'h00);
        dir[9] = mk(3, 8'h00, 0, 0,  0, 8'h01, 0, 0, 1, 8'h01, 8'h00);

        rst = 1'b1;
        rx = 1'b1;
        u_if.ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset.data", u_if.data, 0);
        chk("reset.valid", u_if.valid, 0);
        chk("reset.frame_err", u_if.frame_err, 0);
        chk("reset.overrun", u_if.overrun, 0);
        rst = 1'b0;
        drive_bit(1'b1, 4);

        for (int i = 0; i < 10; i++) run_vec(dir[i], $sformatf("dir%0d", i));

        // Back-to-back frames with ready raised only on the edge that delivers the second byte.
        fe0 = fe_cnt; ov0 = ov_cnt; g0 = got.size();
        send_frame(8'h03, 1'b1);
        fork
            send_frame(8'h04, 1'b1);
            begin
                repeat (78) @(posedge clk);
                #1 u_if.ready = 1'b1;
                @(posedge clk);
                #1 u_if.ready = 1'b0;
            end
        join
        drive_bit(1'b1, 12);
        chk("b2b.accepted", got.size() - g0, 1);
        if (got.size() > g0) chk("b2b.acc0", got[g0], 8'h03);
        chk("b2b.overrun", ov_cnt - ov0, 0);
        chk("b2b.valid", u_if.valid, 1);
        chk("b2b.data", u_if.data, 8'h04);

        // Reset pulse while data bit 4 of 0xFF is on the line.
        fe0 = fe_cnt; ov0 = ov_cnt; g0 = got.size();
        fork
            send_frame(8'hFF, 1'b1);
            begin
                repeat (45) @(posedge clk);
                #1 rst = 1'b1;
                @(posedge clk);
                #1 rst = 1'b0;
                chk("midrst.data", u_if.data, 0);
                chk("midrst.valid", u_if.valid, 0);
                chk("midrst.frame_err", u_if.frame_err, 0);
                chk("midrst.overrun", u_if.overrun, 0);
            end
        join
        drive_bit(1'b1, 12);
        chk("midrst.no_frame_err", fe_cnt - fe0, 0);
        chk("midrst.no_valid", u_if.valid, 0);
        run_vec(mk(0, 8'hC3, 0, 0, 1, 8'hC3, 0, 0, 0, 8'h00, 8'h00), "after_rst");

        m_valid = 1'b1;
        m_data  = 8'hC3;
        for (int i = 0; i < 24; i++) begin
            v.kind  = $urandom_range(0, 5);
            if (v.kind > 3) v.kind = 0;
            v.b     = 8'($urandom);
            v.rdy   = 1'($urandom_range(0, 1));
            v.extra = (v.kind == 2) ? $urandom_range(1, 3) : $urandom_range(0, 40);
            v = model(v);
            run_vec(v, $sformatf("rnd%0d", i));
        end

        chk("fe_ov_overlap", both_cnt, 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- 8N1 UART receiver; the companion of the existing uart_tx.
- Samples the asynchronous serial line `rx` in the 12 MHz `clk` domain and reassembles bytes, LSB first.
- Presents each byte through a one-entry valid/ready output register.
- Flags framing errors and overruns. Sits at the board RX pin and feeds command/echo logic next to hello_world.

Parameters:
- CLKS_PER_BIT, 1250: clk cycles per bit. 12 MHz / 9600 baud. Legal range is 4 or more.
- CNT_W, $clog2(CLKS_PER_BIT): width of the bit-timing counter. Derived; do not override.

Ports:
- clk  in  1  system clock, 12 MHz nominal
- rst  in  1  synchronous, active-high reset
- rx  in  1  asynchronous serial input; idle high
- data  out  8  received byte; stable while valid=1
- valid  out  1  data holds an unconsumed byte
- ready  in  1  consumer accepts data when valid&&ready at a rising clk edge
- frame_err  out  1  one-cycle pulse: stop bit sampled low
- overrun  out  1  one-cycle pulse: completed byte dropped because the output register was full

Behaviour:
- Interface (already decided): one clock; reset is synchronous and active-high; clock and reset ports are clk and rst.
- Reset values:
  - Outputs: data=0, valid=0, frame_err=0, overrun=0.
  - Internals: state=IDLE, counter=0, bit index=0, shift register=0, synchronizer flops=1.
- Synchronizer: 2-flop synchronizer on rx, reset to 1. All logic uses the synchronized value rx_s, which lags rx by 2 cycles.
- States: IDLE, START, DATA, STOP, WAIT_IDLE.
- IDLE:
  - Counter=0.
  - rx_s==0 -> START.
- START:
  - Count to CLKS_PER_BIT/2-1 (integer division).
  - At that point, rx_s==0 -> DATA, counter=0, bit index=0.
  - rx_s==1 -> glitch: return to IDLE with no output.
- DATA:
  - Count to CLKS_PER_BIT-1, then sample rx_s into bit[index] (LSB first) and reset the counter.
  - After index 7 -> STOP; otherwise index+1.
- STOP:
  - Count to CLKS_PER_BIT-1, then sample rx_s.
  - rx_s==1 -> deliver the byte (see below) and go to IDLE.
  - rx_s==0 -> frame_err=1 for exactly one cycle, byte discarded, -> WAIT_IDLE.
- WAIT_IDLE: stay until rx_s==1, then -> IDLE. This prevents a break condition being read as repeated 0x00 frames.
- Delivery, on the clock edge of the good stop sample:
  - valid==0, or valid&&ready in the same cycle -> data<=byte, valid<=1. Simultaneous accept and deliver loads the new byte and valid stays 1.
  - valid==1 && ready==0 -> old data kept, new byte dropped, overrun=1 for one cycle.
- Consumption: valid&&ready with no concurrent delivery -> valid<=0 next edge; data holds its last value.
- Latency: valid rises on the clock edge of the good stop sample (registered, no extra stage). That is about 9.5 bit periods plus 2-4 clk after the rx falling start edge.
- Reset mid-frame: the receiver returns to IDLE on the next edge and the partial byte is discarded. If rx is low at release, that is treated as a new start edge. Pending valid is cleared.
- frame_err and overrun never assert in the same cycle. The bit-timing counter never exceeds CLKS_PER_BIT-1.

Decomposition:
- Shared package uart_pkg:
  - Baud constants: CLKS_PER_BIT_9600_12M = 1250.
  - The UART state enum.
  - DATA_BITS = 8.
  - uart_tx is to be migrated to this package.
- Sub-module sync_2ff: parameterised width, reset value 1; reused for other pins.

Test Plan (CLKS_PER_BIT=8 in sim; frames driven by a bench task or by uart_tx):
- Good frame: frame 0x3F, ready=1 -> valid pulses one cycle with data=0x3F; frame_err=0, overrun=0.
- Held byte: frame 0xAB with ready=0 -> valid stays 1, data=0xAB. Raising ready for one cycle -> valid=0 on the next edge.
- Glitch: rx low for 3 clk, then high -> no valid, state returns to IDLE. A following 0x55 frame is received correctly.
- Framing error: frame 0xA5 with stop bit 0, then rx held low for 40 clk, then high -> frame_err pulses once, no valid. The next frame 0x12 is received.
- Overrun: 0x01 then 0x02 back-to-back with ready=0 -> overrun pulses once, data stays 0x01. Back-to-back 0x03/0x04 with ready=1 on the second delivery cycle -> data=0x04, valid stays 1.
- Reset mid-frame: assert rst for one cycle during data bit 4 of 0xFF -> all outputs 0, no valid. The subsequent frame 0xC3 is received intact.
